hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage core (Fetch, Decode, Execute, Memory, Writeback) around the decode stage and its register file.
- Tracks destination tags of in-flight instructions in EX/MEM/WB.
- Generates stall, flush (bubble) and operand-forwarding selects.
- Holds Execute for multi-cycle multiplies and squashes wrong-path instructions on a taken branch.

Parameters:
ADDRESSWIDTH, 3, register address width (matches regfile)
MUL_LATENCY, 3, cycles a multiply occupies EX (>=1)
BRANCH_PENALTY, 1, cycles flushDecode/flushExecute stay asserted after a taken branch (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; clears all state when 0
idValid  in  1  decode stage holds a real instruction
idReg1Address  in  ADDRESSWIDTH  source 1 of ID instruction
idUsesReg1  in  1  source 1 is read
idReg2Address  in  ADDRESSWIDTH  source 2 of ID instruction
idUsesReg2  in  1  source 2 is read
idDestAddress  in  ADDRESSWIDTH  destination of ID instruction
idWritesReg  in  1  ID instruction writes regfile
idIsLoad  in  1  ID instruction is a memory load
idIsMul  in  1  ID instruction is a multiply
exBranchTaken  in  1  branch in EX resolved taken
stallFetch  out  1  hold PC
stallDecode  out  1  hold IF/ID register
flushDecode  out  1  clear IF/ID register to bubble
flushExecute  out  1  insert bubble into ID/EX
forwardA  out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
forwardB  out  2  same for operand B
exBusy  out  1  EX held by multi-cycle multiply

Behaviour:
- Tags: exTag, memTag, wbTag, each {valid, addr, isLoad, isMul}. EX additionally stores src1/src2 address and use bits.
- Reset (reset=0, async): all tags invalid, state RUN, counter 0, every output 0.
- Tag advance on each clock edge, unless in MUL:
  - wbTag<=memTag, memTag<=exTag.
  - exTag<=ID fields (valid=idValid&idWritesReg) when no stall/flush; otherwise exTag<=bubble.
- Forwarding (combinational from EX source regs):
  - forwardA=01 if usesA & memTag.valid & !memTag.isLoad & memTag.addr==srcA.
  - Else 10 if usesA & wbTag.valid & wbTag.addr==srcA.
  - Else 00. forwardB is identical for source B. EX/MEM wins over MEM/WB.
  - No register is hardwired; all addresses compare.
- loadUse = idValid & exTag.valid & exTag.isLoad & ((idUsesReg1 & idReg1Address==exTag.addr) | (idUsesReg2 & idReg2Address==exTag.addr)).
- FSM states RUN, MUL, FLUSH; priority MUL > branch > loadUse > normal.
- RUN:
  - If exBranchTaken: flushDecode=1, flushExecute=1. If BRANCH_PENALTY>1, go to FLUSH with count=BRANCH_PENALTY-1.
  - Else if loadUse: stallFetch=1, stallDecode=1, flushExecute=1, for exactly 1 cycle.
  - Else if ID instruction advances with idIsMul & MUL_LATENCY>1: next state MUL with count=MUL_LATENCY-1.
- MUL:
  - exBusy=1, stallFetch=1, stallDecode=1; exTag held.
  - Bubble into MEM, i.e. memTag invalid next; wbTag<=memTag.
  - Count decrements; when count==1, next state RUN. Total EX occupancy = MUL_LATENCY cycles.
  - exBranchTaken ignored.
- FLUSH:
  - flushDecode=1, flushExecute=1; count decrements; return to RUN at 1.
  - loadUse ignored (ID is wrong-path).
- Simultaneous exBranchTaken and loadUse: branch wins, no stall.
- Back-to-back multiplies: second mul waits in ID (stalled) and enters EX on the RUN cycle after the first completes.
- Reset asserted mid-MUL or mid-FLUSH: immediate return to RUN with all outputs 0.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10).
  - state_t enum (RUN, MUL, FLUSH).
  - pipe_tag_t struct {valid, addr, isLoad, isMul}.
- One sub-module: forward_select (combinational), instantiated twice for A and B.

Test Plan:
1. ALU r3<=.., next instruction reads r3 as src1 -> in EX cycle forwardA=01, no stall. One intervening instruction -> forwardA=10.
2. Load r2, next instruction reads r2 as src2 -> one cycle stallFetch=stallDecode=flushExecute=1, then forwardB=10, no further stall.
3. MUL_LATENCY=3, mul r4 enters EX -> exBusy=1 for 2 extra cycles (3 total), stalls asserted those 2 cycles, memTag invalid behind it. Dependent reader of r4 then sees forwardA=01.
4. exBranchTaken=1 coincident with loadUse on ID -> flushDecode=flushExecute=1, stallFetch=0. BRANCH_PENALTY=2 -> flushes held for 2 cycles.
5. Assert reset=0 during second cycle of MUL -> exBusy, stalls and forwards drop to 0 immediately (async). After release, an ID read of the mul destination gives forwardA=00.
6. Same register in both sources, matches both memTag and wbTag -> forwardA=forwardB=01.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard sequencer.
package hazard_pkg;

  // Tag address field is sized for the widest supported register file;
  // narrower addresses are zero-extended so every compare stays exact.
  localparam int unsigned TagAddrW = 8;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    MUL,
    FLUSH
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [TagAddrW-1:0] addr;
    logic                is_load;
    logic                is_mul;
  } pipe_tag_t;

  localparam pipe_tag_t BubbleTag = '0;

endpackage

// File: rtl/forward_select.sv
// Operand bypass select for one EX source register.
module forward_select
  import hazard_pkg::*;
(
  input  logic                i_uses,
  input  logic [TagAddrW-1:0] i_src,
  input  pipe_tag_t           i_mem_tag,
  input  pipe_tag_t           i_wb_tag,
  output fwd_sel_t            o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;
  logic w_unused;

  // A load in MEM has no data yet; load-use stalling keeps that case out of EX.
  assign w_mem_hit = i_uses & i_mem_tag.valid & ~i_mem_tag.is_load & (i_mem_tag.addr == i_src);
  assign w_wb_hit  = i_uses & i_wb_tag.valid & (i_wb_tag.addr == i_src);
  assign w_unused  = ^{i_mem_tag.is_mul, i_wb_tag.is_load, i_wb_tag.is_mul};

  // Youngest producer (EX/MEM) takes precedence over MEM/WB.
  always_comb begin
    o_sel = FWD_REG;
    if (w_mem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall / flush / forwarding sequencer for the 5-stage core.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH   = 3,
  parameter int unsigned MUL_LATENCY    = 3,
  parameter int unsigned BRANCH_PENALTY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    idValid,
  input  logic [ADDRESSWIDTH-1:0] idReg1Address,
  input  logic                    idUsesReg1,
  input  logic [ADDRESSWIDTH-1:0] idReg2Address,
  input  logic                    idUsesReg2,
  input  logic [ADDRESSWIDTH-1:0] idDestAddress,
  input  logic                    idWritesReg,
  input  logic                    idIsLoad,
  input  logic                    idIsMul,
  input  logic                    exBranchTaken,
  output logic                    stallFetch,
  output logic                    stallDecode,
  output logic                    flushDecode,
  output logic                    flushExecute,
  output logic [1:0]              forwardA,
  output logic [1:0]              forwardB,
  output logic                    exBusy
);

  localparam int unsigned MaxCnt = (MUL_LATENCY > BRANCH_PENALTY) ? MUL_LATENCY : BRANCH_PENALTY;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] MulCnt   = CntW'(MUL_LATENCY - 1);
  localparam logic [CntW-1:0] FlushCnt = CntW'(BRANCH_PENALTY - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  state_t              r_state, w_state_d;
  logic [CntW-1:0]     r_count, w_count_d;
  pipe_tag_t           r_ex_tag, r_mem_tag, r_wb_tag;
  logic [TagAddrW-1:0] r_ex_src1, r_ex_src2;
  logic                r_ex_use1, r_ex_use2;

  logic [TagAddrW-1:0] w_id_src1, w_id_src2, w_id_dest;
  logic                w_load_use;
  logic                w_stall;
  logic                w_flush_dec;
  logic                w_flush_ex;
  logic                w_busy;
  fwd_sel_t            w_fwd_a, w_fwd_b;
  logic                w_unused;

  assign w_id_src1 = TagAddrW'(idReg1Address);
  assign w_id_src2 = TagAddrW'(idReg2Address);
  assign w_id_dest = TagAddrW'(idDestAddress);
  assign w_unused  = r_ex_tag.is_mul;

  assign w_load_use = idValid & r_ex_tag.valid & r_ex_tag.is_load &
                      ((idUsesReg1 & (w_id_src1 == r_ex_tag.addr)) |
                       (idUsesReg2 & (w_id_src2 == r_ex_tag.addr)));

  forward_select u_fwd_a (
    .i_uses    (r_ex_use1),
    .i_src     (r_ex_src1),
    .i_mem_tag (r_mem_tag),
    .i_wb_tag  (r_wb_tag),
    .o_sel     (w_fwd_a)
  );

  forward_select u_fwd_b (
    .i_uses    (r_ex_use2),
    .i_src     (r_ex_src2),
    .i_mem_tag (r_mem_tag),
    .i_wb_tag  (r_wb_tag),
    .o_sel     (w_fwd_b)
  );

  // Next state and pipeline controls; multiply hold beats branch beats load-use.
  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_stall     = 1'b0;
    w_flush_dec = 1'b0;
    w_flush_ex  = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      RUN: begin
        if (exBranchTaken) begin
          w_flush_dec = 1'b1;
          w_flush_ex  = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            w_state_d = FLUSH;
            w_count_d = FlushCnt;
          end
        end else if (w_load_use) begin
          w_stall    = 1'b1;
          w_flush_ex = 1'b1;
        end else if (idValid && idIsMul && (MUL_LATENCY > 1)) begin
          w_state_d = MUL;
          w_count_d = MulCnt;
        end
      end
      MUL: begin
        w_busy    = 1'b1;
        w_stall   = 1'b1;
        w_count_d = r_count - CntOne;
        if (r_count == CntOne) begin
          w_state_d = RUN;
        end
      end
      FLUSH: begin
        w_flush_dec = 1'b1;
        w_flush_ex  = 1'b1;
        w_count_d   = r_count - CntOne;
        if (r_count == CntOne) begin
          w_state_d = RUN;
        end
      end
      default: begin
        w_state_d = RUN;
        w_count_d = '0;
      end
    endcase
  end

  // FSM state and hold counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
    end
  end

  // Destination tags move down the pipe; EX is frozen while a multiply occupies it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_tag  <= BubbleTag;
      r_mem_tag <= BubbleTag;
      r_wb_tag  <= BubbleTag;
      r_ex_src1 <= '0;
      r_ex_src2 <= '0;
      r_ex_use1 <= 1'b0;
      r_ex_use2 <= 1'b0;
    end else if (r_state == MUL) begin
      r_mem_tag <= BubbleTag;
      r_wb_tag  <= r_mem_tag;
    end else begin
      r_wb_tag  <= r_mem_tag;
      r_mem_tag <= r_ex_tag;
      if (w_stall || w_flush_ex) begin
        r_ex_tag  <= BubbleTag;
        r_ex_src1 <= '0;
        r_ex_src2 <= '0;
        r_ex_use1 <= 1'b0;
        r_ex_use2 <= 1'b0;
      end else begin
        r_ex_tag.valid   <= idValid & idWritesReg;
        r_ex_tag.addr    <= w_id_dest;
        r_ex_tag.is_load <= idIsLoad;
        r_ex_tag.is_mul  <= idIsMul;
        r_ex_src1        <= w_id_src1;
        r_ex_src2        <= w_id_src2;
        r_ex_use1        <= idValid & idUsesReg1;
        r_ex_use2        <= idValid & idUsesReg2;
      end
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign stallFetch   = reset & w_stall;
  assign stallDecode  = reset & w_stall;
  assign flushDecode  = reset & w_flush_dec;
  assign flushExecute = reset & w_flush_ex;
  assign exBusy       = reset & w_busy;
  assign forwardA     = reset ? w_fwd_a : FWD_REG;
  assign forwardB     = reset ? w_fwd_b : FWD_REG;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: stimulus pushes expected controls, a monitor pops and compares.
module tb_hazard_control_unit;

  localparam int unsigned AW = 3;
  localparam int unsigned ML = 3;
  localparam int unsigned BP = 2;

  logic          clock;
  logic          reset;
  logic          idValid, idUsesReg1, idUsesReg2, idWritesReg, idIsLoad, idIsMul;
  logic [AW-1:0] idReg1Address, idReg2Address, idDestAddress;
  logic          exBranchTaken;
  logic          stallFetch, stallDecode, flushDecode, flushExecute, exBusy;
  logic [1:0]    forwardA, forwardB;

  hazard_control_unit #(
    .ADDRESSWIDTH   (AW),
    .MUL_LATENCY    (ML),
    .BRANCH_PENALTY (BP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .idValid       (idValid),
    .idReg1Address (idReg1Address),
    .idUsesReg1    (idUsesReg1),
    .idReg2Address (idReg2Address),
    .idUsesReg2    (idUsesReg2),
    .idDestAddress (idDestAddress),
    .idWritesReg   (idWritesReg),
    .idIsLoad      (idIsLoad),
    .idIsMul       (idIsMul),
    .exBranchTaken (exBranchTaken),
    .stallFetch    (stallFetch),
    .stallDecode   (stallDecode),
    .flushDecode   (flushDecode),
    .flushExecute  (flushExecute),
    .forwardA      (forwardA),
    .forwardB      (forwardB),
    .exBusy        (exBusy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit v; bit wr; int dest; bit ld; bit mul;
    bit u1; int s1; bit u2; int s2;
  } instr_t;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  instr_t nop_i = '{default: 0};

  // Reference pipeline: instruction records per stage plus remaining hold cycles.
  instr_t m_ex, m_mem, m_wb;
  int     mul_left, flush_left;

  function automatic instr_t mk(bit wr, int dest, bit ld, bit mul, bit u1, int s1, bit u2, int s2);
    instr_t r;
    r.v = 1; r.wr = wr; r.dest = dest; r.ld = ld; r.mul = mul;
    r.u1 = u1; r.s1 = s1; r.u2 = u2; r.s2 = s2;
    return r;
  endfunction

  // Youngest completed producer of a register supplies the operand.
  function automatic logic [1:0] model_fwd(bit u, int s);
    if (u && m_mem.wr && !m_mem.ld && m_mem.dest == s) return 2'b01;
    if (u && m_wb.wr && m_wb.dest == s) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input instr_t id, input bit br, input bit rst, output bit taken);
    bit sf, fd, fe, busy, lu;
    logic [1:0] fa, fb;
    exp_t e;
    reset         = !rst;
    idValid       = id.v;
    idWritesReg   = id.wr;
    idDestAddress = AW'(id.dest);
    idIsLoad      = id.ld;
    idIsMul       = id.mul;
    idUsesReg1    = id.u1;
    idReg1Address = AW'(id.s1);
    idUsesReg2    = id.u2;
    idReg2Address = AW'(id.s2);
    exBranchTaken = br;
    sf = 0; fd = 0; fe = 0; busy = 0; fa = 2'b00; fb = 2'b00;
    taken = 1;
    if (rst) begin
      m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;
      mul_left = 0; flush_left = 0;
    end else begin
      fa = model_fwd(m_ex.u1, m_ex.s1);
      fb = model_fwd(m_ex.u2, m_ex.s2);
      lu = id.v && m_ex.wr && m_ex.ld &&
           ((id.u1 && id.s1 == m_ex.dest) || (id.u2 && id.s2 == m_ex.dest));
      if (mul_left > 0) begin
        busy = 1; sf = 1;
      end else if (flush_left > 0 || br) begin
        fd = 1; fe = 1;
      end else if (lu) begin
        sf = 1; fe = 1;
      end
      if (mul_left > 0) begin
        mul_left--;
        m_wb  = m_mem;
        m_mem = nop_i;
      end else begin
        m_wb  = m_mem;
        m_mem = m_ex;
        if (fe) begin
          m_ex = nop_i;
        end else begin
          m_ex    = id;
          m_ex.wr = id.v && id.wr;
          m_ex.u1 = id.v && id.u1;
          m_ex.u2 = id.v && id.u2;
          if (id.v && id.mul) mul_left = ML - 1;
        end
        if (flush_left > 0) flush_left--;
        else if (br) flush_left = BP - 1;
      end
      taken = !sf;
    end
    e.cyc = cyc;
    e.v   = {sf, sf, fd, fe, busy, fa, fb};
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Present one ID instruction until the pipeline accepts or squashes it.
  task automatic issue(input instr_t id, input bit br);
    bit t;
    int n;
    n = 0;
    do begin
      step(id, br, 0, t);
      n++;
    end while (!t && n < 8);
    if (!t) begin
      checks++;
      errors++;
      $display("FAIL issue_bound cyc=%0d still stalled after %0d cycles, required <8", cyc, n);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) issue(nop_i, 0);
  endtask

  // Monitor: compare DUT controls against the oldest expectation, away from the edge.
  initial begin
    exp_t       e;
    logic [8:0] got;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {stallFetch, stallDecode, flushDecode, flushExecute, exBusy, forwardA, forwardB};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL ctl cyc=%0d {sF,sD,fD,fE,busy,fA,fB} got=%b required=%b",
                   e.cyc, got, e.v);
        end
      end
    end
  end

  initial begin
    bit     t;
    instr_t r;
    reset = 1'b0; idValid = 0; idWritesReg = 0; idIsLoad = 0; idIsMul = 0;
    idUsesReg1 = 0; idUsesReg2 = 0; idReg1Address = '0; idReg2Address = '0;
    idDestAddress = '0; exBranchTaken = 0;
    m_ex = nop_i; m_mem = nop_i; m_wb = nop_i; mul_left = 0; flush_left = 0;
    @(posedge clock);
    #1;
    step(nop_i, 0, 1, t);
    step(nop_i, 0, 1, t);

    // ALU result forwarded from EX/MEM, then from MEM/WB with one gap.
    issue(mk(1, 3, 0, 0, 1, 1, 1, 2), 0);
    issue(mk(1, 5, 0, 0, 1, 3, 1, 6), 0);
    issue(mk(1, 3, 0, 0, 1, 1, 1, 2), 0);
    issue(mk(1, 6, 0, 0, 1, 7, 0, 0), 0);
    issue(mk(1, 5, 0, 0, 1, 3, 0, 0), 0);
    drain(3);

    // Load-use on source 2.
    issue(mk(1, 2, 1, 0, 0, 0, 0, 0), 0);
    issue(mk(1, 7, 0, 0, 1, 1, 1, 2), 0);
    drain(3);

    // Multiply hold, then dependent reader; then back-to-back multiplies.
    issue(mk(1, 4, 0, 1, 1, 1, 1, 2), 0);
    issue(mk(1, 5, 0, 0, 1, 4, 0, 0), 0);
    drain(3);
    issue(mk(1, 4, 0, 1, 1, 1, 1, 2), 0);
    issue(mk(1, 5, 0, 1, 1, 4, 1, 4), 0);
    issue(mk(1, 6, 0, 0, 1, 5, 1, 4), 0);
    drain(4);

    // Branch coincident with load-use.
    issue(mk(1, 1, 1, 0, 0, 0, 0, 0), 0);
    issue(mk(1, 2, 0, 0, 1, 1, 0, 0), 1);
    drain(4);

    // Reset during second multiply cycle, then read of the multiply destination.
    issue(mk(1, 4, 0, 1, 1, 2, 1, 3), 0);
    step(nop_i, 0, 0, t);
    step(nop_i, 0, 1, t);
    issue(mk(1, 6, 0, 0, 1, 4, 0, 0), 0);
    drain(3);

    // Same register on both sources, present in MEM and WB.
    issue(mk(1, 5, 0, 0, 0, 0, 0, 0), 0);
    issue(mk(1, 5, 0, 0, 0, 0, 0, 0), 0);
    issue(mk(1, 1, 0, 0, 1, 5, 1, 5), 0);
    drain(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        step(nop_i, 0, 1, t);
      end else begin
        r.v    = ($urandom_range(0, 7) != 0);
        r.wr   = ($urandom_range(0, 3) != 0);
        r.dest = $urandom_range(0, 7);
        r.ld   = ($urandom_range(0, 3) == 0);
        r.mul  = !r.ld && ($urandom_range(0, 7) == 0);
        r.u1   = ($urandom_range(0, 3) != 0);
        r.s1   = $urandom_range(0, 7);
        r.u2   = ($urandom_range(0, 1) != 0);
        r.s2   = $urandom_range(0, 7);
        issue(r, ($urandom_range(0, 9) == 0));
      end
    end
    drain(4);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
